// File: rtl/alu_seq_if.sv
// Request/response bundle for alu_seq.
// The master side issues operations and the slave side is the ALU.
// Signal names keep their i_/o_ prefixes as seen from the ALU.
interface alu_seq_if #(
  parameter int WIDTH = 4
);
  logic             i_valid;
  logic             o_ready;
  logic [1:0]       i_op;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             o_valid;
  logic [WIDTH-1:0] o_y;
  logic             o_overflow;
  logic             o_err;
  logic             i_clr_sticky;
  logic             o_sticky_ovf;
  logic             o_sticky_err;

  modport master (
    output i_valid, i_op, i_a, i_b, i_clr_sticky,
    input  o_ready, o_valid, o_y, o_overflow, o_err, o_sticky_ovf, o_sticky_err
  );

  modport slave (
    input  i_valid, i_op, i_a, i_b, i_clr_sticky,
    output o_ready, o_valid, o_y, o_overflow, o_err, o_sticky_ovf, o_sticky_err
  );
endinterface

// File: rtl/alu_seq.sv
// Sequential ALU: subtract and NAND complete in one cycle; leading-ones
// count and one-hot decode of {B,A} are bit-serial scans of fixed length
// 2*WIDTH. Results are held until the next o_valid. Sticky flags gather
// overflow and error events until they are cleared.
module alu_seq #(
  parameter int WIDTH       = 4,
  parameter bit ZERO_IS_ERR = 1'b1
) (
  input  logic      i_clk,
  input  logic      i_rst,
  alu_seq_if.slave  bus
);
  localparam int CLEN   = 2 * WIDTH;
  localparam int CW_MIN = $clog2(CLEN + 1);
  // The count/index register must hold 2*WIDTH. It is also at least WIDTH
  // bits wide, so that the low WIDTH bits can be sliced straight into o_y.
  localparam int CW     = (CW_MIN > WIDTH) ? CW_MIN : WIDTH;
  localparam logic [CW-1:0] MAX_Y    = CW'((64'd1 << WIDTH) - 64'd1);
  localparam logic [CW-1:0] LAST_POS = CW'(CLEN - 1);

  localparam logic [1:0] OP_SUB    = 2'b00;
  localparam logic [1:0] OP_NAND   = 2'b01;
  localparam logic [1:0] OP_LONES  = 2'b10;
  localparam logic [1:0] OP_ONEHOT = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SCAN = 2'b01,
    S_DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CLEN-1:0]  c_q, c_d;            // operand being scanned, shifted each step
  logic [CW-1:0]    pos_q, pos_d;        // scan step number 0 .. 2*WIDTH-1
  logic [CW-1:0]    val_q, val_d;        // leading-ones count or first-one index
  logic             hit_q, hit_d;        // LO: a zero was seen; OH: a one was found
  logic             multi_q, multi_d;    // OH: a second one was seen
  logic [WIDTH-1:0] y_q, y_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic             sticky_ovf_q, sticky_ovf_d;
  logic             sticky_err_q, sticky_err_d;

  logic [WIDTH-1:0] diff;
  logic             scan_bit;

  // State and datapath registers, all cleared by the synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      op_q         <= '0;
      c_q          <= '0;
      pos_q        <= '0;
      val_q        <= '0;
      hit_q        <= 1'b0;
      multi_q      <= 1'b0;
      y_q          <= '0;
      ovf_q        <= 1'b0;
      err_q        <= 1'b0;
      sticky_ovf_q <= 1'b0;
      sticky_err_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      c_q          <= c_d;
      pos_q        <= pos_d;
      val_q        <= val_d;
      hit_q        <= hit_d;
      multi_q      <= multi_d;
      y_q          <= y_d;
      ovf_q        <= ovf_d;
      err_q        <= err_d;
      sticky_ovf_q <= sticky_ovf_d;
      sticky_err_q <= sticky_err_d;
    end
  end

  // Next-state logic: request capture, one scan step per cycle, and result load on entry to DONE.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    c_d      = c_q;
    pos_d    = pos_q;
    val_d    = val_q;
    hit_d    = hit_q;
    multi_d  = multi_q;
    y_d      = y_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    scan_bit = 1'b0;
    diff     = bus.i_a - bus.i_b;

    case (state_q)
      S_IDLE: begin
        if (bus.i_valid) begin
          op_d    = bus.i_op;
          c_d     = {bus.i_b, bus.i_a};
          pos_d   = '0;
          val_d   = '0;
          hit_d   = 1'b0;
          multi_d = 1'b0;
          if (bus.i_op == OP_SUB) begin
            y_d     = diff;
            ovf_d   = (bus.i_a[WIDTH-1] != bus.i_b[WIDTH-1]) &&
                      (diff[WIDTH-1] != bus.i_a[WIDTH-1]);
            err_d   = 1'b0;
            state_d = S_DONE;
          end else if (bus.i_op == OP_NAND) begin
            y_d     = ~(bus.i_a & bus.i_b);
            ovf_d   = 1'b0;
            err_d   = 1'b0;
            state_d = S_DONE;
          end else begin
            state_d = S_SCAN;
          end
        end
      end

      S_SCAN: begin
        pos_d = pos_q + 1'b1;
        if (op_q == OP_LONES) begin
          // MSB-first: keep counting until the first zero is seen.
          scan_bit = c_q[CLEN-1];
          c_d      = c_q << 1;
          if (!hit_q) begin
            if (scan_bit) begin
              val_d = val_q + 1'b1;
            end else begin
              hit_d = 1'b1;
            end
          end
        end else begin
          // LSB-first: remember where the first one is and flag any later one.
          scan_bit = c_q[0];
          c_d      = c_q >> 1;
          if (scan_bit) begin
            if (!hit_q) begin
              val_d = pos_q;
              hit_d = 1'b1;
            end else begin
              multi_d = 1'b1;
            end
          end
        end

        // The last step is folded into the result so that the result is
        // ready on the same edge that enters DONE.
        if (pos_q == LAST_POS) begin
          state_d = S_DONE;
          y_d     = val_d[WIDTH-1:0];
          ovf_d   = (val_d > MAX_Y);
          if (op_q == OP_ONEHOT) begin
            err_d = multi_d | (!hit_d & ZERO_IS_ERR);
          end else begin
            err_d = 1'b0;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Sticky flags: a clear takes effect unless a flag is being set in the same cycle.
  always_comb begin
    sticky_ovf_d = (bus.i_clr_sticky ? 1'b0 : sticky_ovf_q) |
                   ((state_q == S_DONE) & ovf_q);
    sticky_err_d = (bus.i_clr_sticky ? 1'b0 : sticky_err_q) |
                   ((state_q == S_DONE) & err_q);
  end

  assign bus.o_ready      = (state_q == S_IDLE);
  assign bus.o_valid      = (state_q == S_DONE);
  assign bus.o_y          = y_q;
  assign bus.o_overflow   = ovf_q;
  assign bus.o_err        = err_q;
  assign bus.o_sticky_ovf = sticky_ovf_q;
  assign bus.o_sticky_err = sticky_err_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed testbench for alu_seq: a table of operations with hand-computed
// results, run on a WIDTH=4 unit, a WIDTH=2 unit and a ZERO_IS_ERR=0 unit,
// followed by hand-written handshake, sticky-flag and reset sequences.
module tb_alu_seq;
  logic clk;
  logic rst;

  alu_seq_if #(.WIDTH(4)) bus0 ();
  alu_seq_if #(.WIDTH(2)) bus1 ();
  alu_seq_if #(.WIDTH(4)) bus2 ();

  alu_seq #(.WIDTH(4), .ZERO_IS_ERR(1'b1)) dut0 (.i_clk(clk), .i_rst(rst), .bus(bus0));
  alu_seq #(.WIDTH(2), .ZERO_IS_ERR(1'b1)) dut1 (.i_clk(clk), .i_rst(rst), .bus(bus1));
  alu_seq #(.WIDTH(4), .ZERO_IS_ERR(1'b0)) dut2 (.i_clk(clk), .i_rst(rst), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         sel;   // 0: W4 main, 1: W2, 2: W4 with ZERO_IS_ERR=0
    logic [1:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] y;
    logic       ovf;
    logic       err;
    int         lat;
  } vec_t;

  localparam int NVEC = 17;
  vec_t vecs [NVEC];

  int check_cnt = 0;
  int pass_cnt  = 0;

  task automatic check(input string name, input int act, input int exp);
    check_cnt++;
    if (act == exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int sel, input logic v, input logic [1:0] op,
                       input logic [3:0] a, input logic [3:0] b);
    case (sel)
      0: begin bus0.i_valid = v; bus0.i_op = op; bus0.i_a = a;      bus0.i_b = b;      end
      1: begin bus1.i_valid = v; bus1.i_op = op; bus1.i_a = a[1:0]; bus1.i_b = b[1:0]; end
      default: begin bus2.i_valid = v; bus2.i_op = op; bus2.i_a = a; bus2.i_b = b; end
    endcase
  endtask

  task automatic sample(input int sel, output logic vl, output logic rd,
                        output logic [3:0] y, output logic ov, output logic er);
    case (sel)
      0: begin vl = bus0.o_valid; rd = bus0.o_ready; y = bus0.o_y;
               ov = bus0.o_overflow; er = bus0.o_err; end
      1: begin vl = bus1.o_valid; rd = bus1.o_ready; y = {2'b00, bus1.o_y};
               ov = bus1.o_overflow; er = bus1.o_err; end
      default: begin vl = bus2.o_valid; rd = bus2.o_ready; y = bus2.o_y;
               ov = bus2.o_overflow; er = bus2.o_err; end
    endcase
  endtask

  // Called 1 time unit after a rising edge with the unit idle; returns 1 unit
  // after the edge that brings it back to IDLE following the result.
  task automatic run_vec(input vec_t v, input string tag);
    logic       vl, rd, ov, er;
    logic [3:0] y;
    int         lat;
    drive(v.sel, 1'b1, v.op, v.a, v.b);
    @(posedge clk); #1;
    // Scramble operands after acceptance: the captured values must be used.
    drive(v.sel, 1'b0, ~v.op, ~v.a, ~v.b);
    lat = 1;
    sample(v.sel, vl, rd, y, ov, er);
    while (!vl && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      sample(v.sel, vl, rd, y, ov, er);
    end
    check({tag, "_lat"}, lat, v.lat);
    check({tag, "_y"},   int'(y),  int'(v.y));
    check({tag, "_ovf"}, int'(ov), int'(v.ovf));
    check({tag, "_err"}, int'(er), int'(v.err));
    @(posedge clk); #1;
    sample(v.sel, vl, rd, y, ov, er);
    check({tag, "_rdy_after"}, int'(rd), 1);
    $display("vec %s sel=%0d op=%b a=%b b=%b -> y=%b ovf=%b err=%b lat=%0d",
             tag, v.sel, v.op, v.a, v.b, y, ov, er, lat);
  endtask

  initial begin
    int nval;
    // sel, op, a, b, y, ovf, err, latency
    vecs[0]  = '{0, 2'b00, 4'b0111, 4'b1111, 4'b1000, 1'b1, 1'b0, 1};
    vecs[1]  = '{0, 2'b01, 4'b1100, 4'b1010, 4'b0111, 1'b0, 1'b0, 1};
    vecs[2]  = '{0, 2'b00, 4'b0011, 4'b0001, 4'b0010, 1'b0, 1'b0, 1};
    vecs[3]  = '{0, 2'b00, 4'b1000, 4'b0001, 4'b0111, 1'b1, 1'b0, 1};
    vecs[4]  = '{0, 2'b01, 4'b1111, 4'b1111, 4'b0000, 1'b0, 1'b0, 1};
    vecs[5]  = '{0, 2'b10, 4'b1011, 4'b1111, 4'b0101, 1'b0, 1'b0, 9};
    vecs[6]  = '{0, 2'b10, 4'b1111, 4'b0111, 4'b0000, 1'b0, 1'b0, 9};
    vecs[7]  = '{0, 2'b10, 4'b1111, 4'b1111, 4'b1000, 1'b0, 1'b0, 9};
    vecs[8]  = '{0, 2'b11, 4'b0100, 4'b0000, 4'b0010, 1'b0, 1'b0, 9};
    vecs[9]  = '{0, 2'b11, 4'b0100, 4'b0001, 4'b0010, 1'b0, 1'b1, 9};
    vecs[10] = '{0, 2'b11, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 9};
    vecs[11] = '{0, 2'b11, 4'b0000, 4'b1000, 4'b0111, 1'b0, 1'b0, 9};
    vecs[12] = '{1, 2'b10, 4'b0011, 4'b0011, 4'b0000, 1'b1, 1'b0, 5};
    vecs[13] = '{1, 2'b11, 4'b0000, 4'b0010, 4'b0011, 1'b0, 1'b0, 5};
    vecs[14] = '{1, 2'b00, 4'b0001, 4'b0010, 4'b0011, 1'b1, 1'b0, 1};
    vecs[15] = '{2, 2'b11, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 9};
    vecs[16] = '{2, 2'b11, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 9};

    rst = 1'b1;
    drive(0, 1'b0, 2'b00, 4'h0, 4'h0);
    drive(1, 1'b0, 2'b00, 4'h0, 4'h0);
    drive(2, 1'b0, 2'b00, 4'h0, 4'h0);
    bus0.i_clr_sticky = 1'b0;
    bus1.i_clr_sticky = 1'b0;
    bus2.i_clr_sticky = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    check("rst_ready", int'(bus0.o_ready), 1);
    check("rst_valid", int'(bus0.o_valid), 0);
    check("rst_y",     int'(bus0.o_y), 0);
    check("rst_ovf",   int'(bus0.o_overflow), 0);
    check("rst_err",   int'(bus0.o_err), 0);
    check("rst_sovf",  int'(bus0.o_sticky_ovf), 0);
    check("rst_serr",  int'(bus0.o_sticky_err), 0);
    $display("reset: ready=%b valid=%b y=%b", bus0.o_ready, bus0.o_valid, bus0.o_y);

    // Table-driven operations
    for (int i = 0; i < NVEC; i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
      if (i == 0) check("v0_sticky_ovf", int'(bus0.o_sticky_ovf), 1);
    end

    // A request presented during DONE is ignored.
    drive(0, 1'b1, 2'b01, 4'b1100, 4'b1010);
    @(posedge clk); #1;
    drive(0, 1'b1, 2'b00, 4'b0111, 4'b0001);
    check("done_valid", int'(bus0.o_valid), 1);
    check("done_ready", int'(bus0.o_ready), 0);
    @(posedge clk); #1;
    drive(0, 1'b0, 2'b00, 4'h0, 4'h0);
    check("ign_ready", int'(bus0.o_ready), 1);
    check("ign_y_held", int'(bus0.o_y), 7);
    nval = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (bus0.o_valid) nval++;
    end
    check("ign_no_valid", nval, 0);
    $display("ignored request during DONE: extra valids=%0d", nval);

    // Sticky flags: a standalone clear, then set-wins when a clear and a set coincide.
    bus0.i_clr_sticky = 1'b1;
    @(posedge clk); #1;
    check("clr_serr", int'(bus0.o_sticky_err), 0);
    check("clr_sovf", int'(bus0.o_sticky_ovf), 0);
    run_vec(vecs[9], "sticky_err_req");
    check("setwins_serr", int'(bus0.o_sticky_err), 1);
    check("setwins_sovf", int'(bus0.o_sticky_ovf), 0);
    bus0.i_clr_sticky = 1'b0;
    @(posedge clk); #1;
    check("serr_hold", int'(bus0.o_sticky_err), 1);
    bus0.i_clr_sticky = 1'b1;
    @(posedge clk); #1;
    bus0.i_clr_sticky = 1'b0;
    check("serr_cleared", int'(bus0.o_sticky_err), 0);
    $display("sticky sequence: serr=%b sovf=%b", bus0.o_sticky_err, bus0.o_sticky_ovf);

    // Load a nonzero result and sticky overflow, then reset in the middle of a scan.
    run_vec(vecs[0], "pre_rst_sub");
    check("pre_rst_sovf", int'(bus0.o_sticky_ovf), 1);
    drive(0, 1'b1, 2'b10, 4'b1011, 4'b1111);
    @(posedge clk); #1;
    drive(0, 1'b0, 2'b00, 4'h0, 4'h0);
    repeat (3) begin @(posedge clk); #1; end
    check("midscan_ready", int'(bus0.o_ready), 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mrst_ready", int'(bus0.o_ready), 1);
    check("mrst_valid", int'(bus0.o_valid), 0);
    check("mrst_y",     int'(bus0.o_y), 0);
    check("mrst_ovf",   int'(bus0.o_overflow), 0);
    check("mrst_sovf",  int'(bus0.o_sticky_ovf), 0);
    check("mrst_serr",  int'(bus0.o_sticky_err), 0);
    nval = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (bus0.o_valid) nval++;
    end
    check("mrst_no_valid", nval, 0);
    $display("reset mid-scan: ready=%b y=%b valids after=%0d", bus0.o_ready, bus0.o_y, nval);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
